axi4l_reg_slave: RTL and testbench

AXI4L_REG_SLAVE -- requirements
Module: axi4l_reg_slave

---
 rtl/axi4l_reg_slave.sv | 185 ++++++++++++++++++
 tb/tb_axi4l_reg_slave.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite register slave: NUM_REGS DATA_WIDTH-bit registers with byte strobes.
// The write path is a small FSM that accepts AW and W in either order. The read
// path runs independently. All channel outputs come straight from flops.
module axi4l_reg_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int IDXW  = ADDR_WIDTH - OFS;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, HAVE_AW, HAVE_W, RESP} wstate_e;

  wstate_e                               state_q, state_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   regs_q;
  logic [IDXW-1:0]                       aw_idx_q;
  logic [DATA_WIDTH-1:0]                 w_data_q;
  logic [BYTES-1:0]                      w_strb_q;
  logic                                  awready_q, awready_d, wready_q, wready_d;
  logic                                  bvalid_q, bvalid_d;
  logic [1:0]                            bresp_q, bresp_d;
  logic [NUM_REGS-1:0]                   wr_pulse_q, wr_pulse_d;
  logic                                  arready_q, rvalid_q;
  logic [DATA_WIDTH-1:0]                 rdata_q, rd_word;
  logic [1:0]                            rresp_q;

  logic                  aw_hs, w_hs, ar_hs, do_wr, wr_ok, rd_ok;
  logic [IDXW-1:0]       aw_idx_in, rd_idx, wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BYTES-1:0]      wr_strb;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{awprot, arprot, awaddr[OFS-1:0], araddr[OFS-1:0]};

  assign aw_hs     = awvalid & awready_q;
  assign w_hs      = wvalid & wready_q;
  assign ar_hs     = arvalid & arready_q;
  assign aw_idx_in = awaddr[ADDR_WIDTH-1:OFS];
  assign rd_idx    = araddr[ADDR_WIDTH-1:OFS];
  assign rd_ok     = {1'b0, rd_idx} < (IDXW+1)'(NUM_REGS);
  assign wr_ok     = do_wr && ({1'b0, wr_idx} < (IDXW+1)'(NUM_REGS));

  // Write FSM next state. The commit happens on the edge that completes the second of AW/W.
  always_comb begin
    state_d  = state_q;
    do_wr    = 1'b0;
    wr_idx   = aw_idx_q;
    wr_data  = w_data_q;
    wr_strb  = w_strb_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    case (state_q)
      IDLE: begin
        if (aw_hs && w_hs) begin
          do_wr = 1'b1; wr_idx = aw_idx_in; wr_data = wdata; wr_strb = wstrb;
        end else if (aw_hs) begin
          state_d = HAVE_AW;
        end else if (w_hs) begin
          state_d = HAVE_W;
        end
      end
      HAVE_AW: if (w_hs) begin
        do_wr = 1'b1; wr_data = wdata; wr_strb = wstrb;
      end
      HAVE_W: if (aw_hs) begin
        do_wr = 1'b1; wr_idx = aw_idx_in;
      end
      RESP: if (bready) begin
        state_d  = IDLE;
        bvalid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (do_wr) begin
      state_d  = RESP;
      bvalid_d = 1'b1;
      bresp_d  = wr_ok ? OKAY : SLVERR;
    end
    // Readiness follows the state being entered, so it drops the cycle after a handshake.
    awready_d = (state_d == IDLE) || (state_d == HAVE_W);
    wready_d  = (state_d == IDLE) || (state_d == HAVE_AW);
    for (int i = 0; i < NUM_REGS; i++)
      wr_pulse_d[i] = wr_ok && (wr_idx == IDXW'(i));
  end

  // Read mux. Out-of-range indices match no register and return zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_idx == IDXW'(i)) rd_word = regs_q[i];
  end

  // Write-side state, holding registers and the register file.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      regs_q     <= '0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      wr_pulse_q <= '0;
    end else begin
      state_q    <= state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      if (aw_hs) aw_idx_q <= aw_idx_in;
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_pulse_d[i])
          for (int b = 0; b < BYTES; b++)
            if (wr_strb[b]) regs_q[i][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  // Read channel. A register read on the same edge as a write sees the old value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else if (ar_hs) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b1;
      rdata_q   <= rd_word;
      rresp_q   <= rd_ok ? OKAY : SLVERR;
    end else if (rvalid_q && rready) begin
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
    end else if (!rvalid_q) begin
      arready_q <= 1'b1;
    end
  end

  assign awready    = awready_q;
  assign wready     = wready_q;
  assign bvalid     = bvalid_q;
  assign bresp      = bresp_q;
  assign arready    = arready_q;
  assign rvalid     = rvalid_q;
  assign rdata      = rdata_q;
  assign rresp      = rresp_q;
  assign regs_o     = regs_q;
  assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_axi4l_reg_slave.sv
// Directed bench for axi4l_reg_slave with default parameters (12/32/16).
module tb_axi4l_reg_slave;
  logic         aclk = 1'b0, aresetn = 1'b0;
  logic [11:0]  awaddr = '0, araddr = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [511:0] regs_o, saved;
  logic [15:0]  wr_pulse_o;
  int nvec = 0, nerr = 0;

  axi4l_reg_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk); #1;
  endtask

  // Present AW and W together; returns one edge after the handshake.
  task automatic wr_both(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    step();
    awvalid = 0; wvalid = 0;
  endtask

  task automatic rd_addr(input logic [11:0] a);
    araddr = a; arvalid = 1;
    step();
    arvalid = 0;
  endtask

  initial begin
    // Reset held for 5 cycles
    repeat (5) @(posedge aclk);
    #1;
    chk("rst_awready", awready, 0); chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0); chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);   chk("rst_rdata", rdata, 0);
    chk("rst_pulse", wr_pulse_o, 0); chk("rst_regs", regs_o == '0, 1);
    @(negedge aclk); aresetn = 1;
    step();
    chk("rel_awready", awready, 1); chk("rel_wready", wready, 1);
    chk("rel_arready", arready, 1);

    // Simultaneous AW/W to register 1
    bready = 1; rready = 1;
    wr_both(12'h004, 32'hDEADBEEF, 4'hF);
    chk("sim_bvalid", bvalid, 1); chk("sim_bresp", bresp, 0);
    chk("sim_pulse", wr_pulse_o, 16'h0002); chk("sim_reg1", regs_o[32 +: 32], 32'hDEADBEEF);
    chk("sim_awready_lo", awready, 0);
    step();
    chk("sim_bvalid_clr", bvalid, 0); chk("sim_pulse_clr", wr_pulse_o, 0);
    chk("sim_readys", {awready, wready}, 2'b11);
    rd_addr(12'h004);
    chk("rd1_rvalid", rvalid, 1); chk("rd1_rdata", rdata, 32'hDEADBEEF); chk("rd1_rresp", rresp, 0);
    step();
    chk("rd1_rvalid_clr", rvalid, 0); chk("rd1_arready", arready, 1);

    // W leads AW by 3 cycles, low half-word strobe
    wdata = 32'h0000ABCD; wstrb = 4'h3; wvalid = 1;
    step();
    wvalid = 0;
    chk("wl_wready_lo", wready, 0); chk("wl_awready_hi", awready, 1); chk("wl_bvalid0", bvalid, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("wl_bvalid_wait", bvalid, 0);
    end
    awaddr = 12'h004; awvalid = 1;
    step();
    awvalid = 0;
    chk("wl_bvalid", bvalid, 1); chk("wl_reg1", regs_o[32 +: 32], 32'hDEADABCD);
    chk("wl_pulse", wr_pulse_o, 16'h0002);
    step();

    // Out of range write and read
    saved = regs_o;
    wr_both(12'h040, 32'h12345678, 4'hF);
    chk("oor_bvalid", bvalid, 1); chk("oor_bresp", bresp, 2'b10);
    chk("oor_pulse", wr_pulse_o, 0); chk("oor_regs", regs_o == saved, 1);
    step();
    rd_addr(12'h040);
    chk("oor_rdata", rdata, 0); chk("oor_rresp", rresp, 2'b10);
    step();

    // Zero strobe: pulse fires, data unchanged
    wr_both(12'h009, 32'hFFFFFFFF, 4'h0);
    chk("z_pulse", wr_pulse_o, 16'h0004); chk("z_reg2", regs_o[64 +: 32], 0);
    step();

    // Read backpressure
    rready = 0;
    rd_addr(12'h004);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid", rvalid, 1); chk("bp_rdata", rdata, 32'hDEADABCD); chk("bp_arready", arready, 0);
      step();
    end
    rready = 1;
    step();
    chk("bp_rvalid_clr", rvalid, 0); chk("bp_arready_set", arready, 1);

    // Write backpressure
    bready = 0;
    wr_both(12'h008, 32'h12345678, 4'hF);
    for (int i = 0; i < 5; i++) begin
      chk("bpw_bvalid", bvalid, 1); chk("bpw_bresp", bresp, 0);
      chk("bpw_readys", {awready, wready}, 2'b00);
      step();
    end
    bready = 1;
    step();
    chk("bpw_bvalid_clr", bvalid, 0); chk("bpw_readys_set", {awready, wready}, 2'b11);

    // Read and write the same register on the same edge -> old value
    araddr = 12'h008; arvalid = 1;
    wr_both(12'h008, 32'hCAFEF00D, 4'hF);
    arvalid = 0;
    chk("rw_rdata", rdata, 32'h12345678); chk("rw_reg2", regs_o[64 +: 32], 32'hCAFEF00D);
    step();

    // Reset while in RESP
    bready = 0;
    wr_both(12'h004, 32'h11111111, 4'hF);
    chk("mr_bvalid_pre", bvalid, 1);
    aresetn = 0; #1;
    chk("mr_bvalid", bvalid, 0); chk("mr_reg1", regs_o[32 +: 32], 0);
    chk("mr_pulse", wr_pulse_o, 0);
    @(negedge aclk); aresetn = 1; bready = 1;
    step();
    wr_both(12'h00C, 32'h55AA55AA, 4'hF);
    chk("mr_new_bvalid", bvalid, 1); chk("mr_new_bresp", bresp, 0);
    chk("mr_new_reg3", regs_o[96 +: 32], 32'h55AA55AA);
    step();
    chk("mr_done", bvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
